imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the immediate decoder: takes a sign-extended XLEN immediate and an
//  immediate type, and scatters its bits into the 25-bit opcode-stripped
//  instruction field (bit p = instruction bit p+`OPCODE_LEN).
//  Sits in the instruction assembler / self-test generator path, ahead of the
//  field merger that ORs in rd/rs1/rs2/funct bits.
//  Two-stage valid/ready pipeline with optional encodability checks.
// PARAMETERS
//  (none local) widths come from constants.sv: `XLEN, `MAX_IMM_LEN, `OPCODE_LEN,
//  `IMM_TYPE_BITS_COUNT, `IMM_TYPE_I/S/B/U/J
// PORTS
//  clk        in   1                     clock, all state on rising edge
//  rst_n      in   1                     async active-low reset
//  in_valid   in   1                     input beat valid
//  in_ready   out  1                     encoder can accept a beat
//  in_imm     in   `XLEN                 sign-extended immediate value
//  in_type    in   `IMM_TYPE_BITS_COUNT  immediate type
//  out_valid  out  1                     output beat valid
//  out_ready  in   1                     downstream accepts beat
//  out_field  out  `MAX_IMM_LEN          encoded field, non-imm positions = 0
//  out_err_range out 1                   value not representable in type
//  out_err_align out 1                   B/J value odd
//  out_err_type  out 1                   in_type not one of I/S/B/U/J
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): s1_valid=s2_valid=0; out_valid=0,
//    out_field=0, all err outputs=0. Reset mid-flight discards both stages.
//  - Transfer on valid&ready at clk edge. Latency 2 cycles in->out, throughput
//    1/cycle. S2 loads when !s2_valid | out_ready; S1 loads when S1 empty or S1
//    moves to S2. in_ready = !s1_valid | (!s2_valid | out_ready) (comb).
//  - S1 registers imm/type and computes checks; S2 registers scattered field+flags.
//  - out_* stable while out_valid & !out_ready. No combinational in->out path.
//  - Field mapping (instr bit <- imm bit; field bit = instr bit - 7):
//    I: [31:20]<-[11:0]            S: [31:25]<-[11:5], [11:7]<-[4:0]
//    B: [31]<-[12],[30:25]<-[10:5],[11:8]<-[4:1],[7]<-[11]
//    U: [31:12]<-[31:12]           J: [31]<-[20],[30:21]<-[10:1],[20]<-[11],[19:12]<-[19:12]
//  - All field bits not listed for the type are 0.
//  - Range rule: bits [XLEN-1:N-1] of in_imm all equal, N = 12 (I,S), 13 (B),
//    21 (J), 32 (U); U additionally requires in_imm[11:0]==0 (else err_range).
//  - Align: B/J with in_imm[0]=1 -> err_align; field still encoded (bit0 dropped).
//  - Bad type: err_type=1, out_field=0, other flags 0; beat still passes through.
//  - Flags are per beat, not sticky; several may be set at once (range+align).
// CONFIGURATION
//  IMM_ENC_RANGE_CHECK_EN defined: err_range/err_align computed as above.
//  Not defined: err_range=err_align=0 always; values silently truncated;
//  err_type still active. Pipeline timing identical in both builds.
// TESTING
//  1 I, imm=0xFFFFFFFF -> 2 cycles later out_field=0x1FFE000, no flags
//  2 B, imm=0xFFFFFFFC -> out_field=0x1FC001D; U, imm=0x12345000 -> 0x02468A0
//  3 I, imm=2048 -> err_range=1 (CHECK_EN) / 0 (no CHECK_EN); J, imm=3 -> err_align=1
//  4 type=7 (illegal) -> out_field=0, err_type=1, beat order preserved
//  5 3 back-to-back beats, out_ready=0 3 cycles -> in_ready=0 after 2 accepted,
//    out stable, then all 3 emerge in order on consecutive cycles
//  6 rst_n low with both stages full -> out_valid=0 immediately, no beat emerges

Source files
------------

// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a sign-extended immediate into the 25-bit opcode-stripped field.
// Optional build macro IMM_ENC_RANGE_CHECK_EN enables range and alignment flags.
`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef MAX_IMM_LEN
`define MAX_IMM_LEN 25
`endif
`ifndef OPCODE_LEN
`define OPCODE_LEN 7
`endif
`ifndef IMM_TYPE_BITS_COUNT
`define IMM_TYPE_BITS_COUNT 3
`endif
`ifndef IMM_TYPE_I
`define IMM_TYPE_I 0
`endif
`ifndef IMM_TYPE_S
`define IMM_TYPE_S 1
`endif
`ifndef IMM_TYPE_B
`define IMM_TYPE_B 2
`endif
`ifndef IMM_TYPE_U
`define IMM_TYPE_U 3
`endif
`ifndef IMM_TYPE_J
`define IMM_TYPE_J 4
`endif

module imm_encoder (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [`XLEN-1:0]                in_imm,
  input  logic [`IMM_TYPE_BITS_COUNT-1:0] in_type,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [`MAX_IMM_LEN-1:0]         out_field,
  output logic                            out_err_range,
  output logic                            out_err_align,
  output logic                            out_err_type
);

  localparam int unsigned XW = `XLEN;
  localparam int unsigned FW = `MAX_IMM_LEN;
  localparam int unsigned TW = `IMM_TYPE_BITS_COUNT;

  localparam logic [TW-1:0] T_I = TW'(`IMM_TYPE_I);
  localparam logic [TW-1:0] T_S = TW'(`IMM_TYPE_S);
  localparam logic [TW-1:0] T_B = TW'(`IMM_TYPE_B);
  localparam logic [TW-1:0] T_U = TW'(`IMM_TYPE_U);
  localparam logic [TW-1:0] T_J = TW'(`IMM_TYPE_J);

  logic          s1_valid;
  logic [XW-1:0] s1_imm;
  logic [TW-1:0] s1_type;
  logic          s2_load;
  logic          s1_load;

  logic [FW-1:0] field_c;
  logic          bad_type_c;
  logic          err_range_c;
  logic          err_align_c;

  // S2 frees up when empty or draining; S1 can take a beat if empty or moving on
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_type  <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_imm   <= in_imm;
      s1_type  <= in_type;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Bit scatter; field bit p corresponds to instruction bit p+OPCODE_LEN
  always_comb begin
    field_c    = '0;
    bad_type_c = 1'b0;
    case (s1_type)
      T_I: field_c[24:13] = s1_imm[11:0];
      T_S: begin
        field_c[24:18] = s1_imm[11:5];
        field_c[4:0]   = s1_imm[4:0];
      end
      T_B: begin
        field_c[24]    = s1_imm[12];
        field_c[23:18] = s1_imm[10:5];
        field_c[4:1]   = s1_imm[4:1];
        field_c[0]     = s1_imm[11];
      end
      T_U: field_c[24:5] = s1_imm[31:12];
      T_J: begin
        field_c[24]    = s1_imm[20];
        field_c[23:14] = s1_imm[10:1];
        field_c[13]    = s1_imm[11];
        field_c[12:5]  = s1_imm[19:12];
      end
      default: bad_type_c = 1'b1;
    endcase
  end

`ifdef IMM_ENC_RANGE_CHECK_EN
  // True when bits [XW-1:n-1] are a pure sign extension
  function automatic logic fits(input logic [XW-1:0] v, input int unsigned n);
    logic [XW-1:0] hi;
    hi = XW'($signed(v) >>> (n - 1));
    return (hi == '0) || (&hi);
  endfunction

  always_comb begin
    err_range_c = 1'b0;
    err_align_c = 1'b0;
    case (s1_type)
      T_I, T_S: err_range_c = !fits(s1_imm, 12);
      T_B: begin
        err_range_c = !fits(s1_imm, 13);
        err_align_c = s1_imm[0];
      end
      T_U: err_range_c = |s1_imm[11:0];
      T_J: begin
        err_range_c = !fits(s1_imm, 21);
        err_align_c = s1_imm[0];
      end
      default: begin
        err_range_c = 1'b0;
        err_align_c = 1'b0;
      end
    endcase
  end
`else
  assign err_range_c = 1'b0;
  assign err_align_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_field     <= '0;
      out_err_range <= 1'b0;
      out_err_align <= 1'b0;
      out_err_type  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_field     <= field_c;
        out_err_range <= err_range_c;
        out_err_align <= err_align_c;
        out_err_type  <= bad_type_c;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed spec cases plus randomized traffic against a scoreboard model.
`timescale 1ns/1ps

module tb_imm_encoder;

  typedef struct packed {
    logic [24:0] field;
    logic        er;
    logic        ea;
    logic        et;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_imm = '0;
  logic [2:0]  in_type = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_field;
  logic        out_err_range;
  logic        out_err_align;
  logic        out_err_type;

  int passed = 0;
  int total  = 0;

  exp_t        q[$];
  bit          prev_stall = 1'b0;
  logic [27:0] prev_out;
  bit          popped;
  logic [24:0] last_field;
  logic        last_er, last_ea, last_et;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_type(in_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field),
    .out_err_range(out_err_range), .out_err_align(out_err_align), .out_err_type(out_err_type)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within 1ms");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else passed++;
  endtask

  // Immediate bit feeding instruction bit p for type t, or -1 when p is not an immediate position
  function automatic int imm_src(input logic [2:0] t, input int p);
    case (t)
      3'd0: return (p >= 20) ? p - 20 : -1;
      3'd1: return (p >= 25) ? p - 20 : (p >= 7 && p <= 11) ? p - 7 : -1;
      3'd2: begin
        if (p == 31) return 12;
        if (p >= 25) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
        if (p == 7) return 11;
        return -1;
      end
      3'd3: return (p >= 12) ? p : -1;
      3'd4: begin
        if (p == 31) return 20;
        if (p >= 21) return p - 20;
        if (p == 20) return 11;
        if (p >= 12) return p;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] imm, input logic [2:0] t);
    exp_t        e;
    logic [31:0] instr;
    longint      v;
    int          src;
    e = '0;
    instr = '0;
    v = longint'($signed(imm));
    if (t > 3'd4) begin
      e.et = 1'b1;
      return e;
    end
    for (int p = 7; p < 32; p++) begin
      src = imm_src(t, p);
      if (src >= 0) instr[p] = imm[src];
    end
    e.field = instr[31:7];
`ifdef IMM_ENC_RANGE_CHECK_EN
    case (t)
      3'd0, 3'd1: e.er = (v < -2048) || (v > 2047);
      3'd2: begin
        e.er = (v < -4096) || (v > 4095);
        e.ea = imm[0];
      end
      3'd3: e.er = (imm[11:0] != 12'd0);
      default: begin
        e.er = (v < -64'sd1048576) || (v > 64'sd1048575);
        e.ea = imm[0];
      end
    endcase
`endif
    return e;
  endfunction

  // One cycle: sample at negedge+1, score handshakes, then advance to the next negedge
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    popped = 1'b0;
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_stable", 32'({out_field, out_err_range, out_err_align, out_err_type}), 32'(prev_out));
    end
    if (out_valid && out_ready) begin
      check("q_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("field", 32'(out_field), 32'(e.field));
        check("err_range", 32'(out_err_range), 32'(e.er));
        check("err_align", 32'(out_err_align), 32'(e.ea));
        check("err_type", 32'(out_err_type), 32'(e.et));
      end
      last_field = out_field;
      last_er = out_err_range;
      last_ea = out_err_align;
      last_et = out_err_type;
      popped = 1'b1;
    end
    if (acc) q.push_back(model(in_imm, in_type));
    prev_stall = out_valid && !out_ready;
    prev_out = {out_field, out_err_range, out_err_align, out_err_type};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input logic [31:0] imm, input logic [2:0] t);
    bit acc;
    bit done;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_imm = imm;
    in_type = t;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) tick(acc);
    check("send_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick(acc);
      done = popped;
    end
    check("send_emerged", 32'(done), 32'd1);
  endtask

  initial begin
    bit acc;
    int mode;
    logic [31:0] edges[12];
    edges = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4095, 32'd4096,
              32'hFFFFF000, 32'hFFFFEFFF, 32'h000FFFFF, 32'h00100000, 32'hFFF00000, 32'hFFEFFFFF};

    // Reset state while held in reset
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_field", 32'(out_field), 32'd0);
    check("rst_errs", 32'({out_err_range, out_err_align, out_err_type}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-cycle latency and I-type all-ones
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_imm = 32'hFFFFFFFF;
    in_type = 3'd0;
    tick(acc);
    check("lat_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    check("lat_cycle1", 32'(out_valid), 32'd0);
    tick(acc);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    tick(acc);
    check("i_ones_popped", 32'(popped), 32'd1);
    check("i_ones_field", 32'(last_field), 32'h1FFE000);
    check("i_ones_flags", 32'({last_er, last_ea, last_et}), 32'd0);

    send_one(32'hFFFFFFFC, 3'd2);
    check("b_field", 32'(last_field), 32'h1FC001D);
    send_one(32'h12345000, 3'd3);
    check("u_field", 32'(last_field), 32'h02468A0);
    send_one(32'd2048, 3'd0);
`ifdef IMM_ENC_RANGE_CHECK_EN
    check("i2048_range", 32'(last_er), 32'd1);
`else
    check("i2048_range", 32'(last_er), 32'd0);
`endif
    send_one(32'd3, 3'd4);
`ifdef IMM_ENC_RANGE_CHECK_EN
    check("j3_align", 32'(last_ea), 32'd1);
`else
    check("j3_align", 32'(last_ea), 32'd0);
`endif
    send_one(32'h00001234, 3'd7);
    check("bad_field", 32'(last_field), 32'd0);
    check("bad_flags", 32'({last_er, last_ea, last_et}), 32'd1);

    // Back-to-back beats under backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_imm = 32'd5;    in_type = 3'd0; tick(acc); check("bp_acc1", 32'(acc), 32'd1);
    in_imm = 32'd7;    in_type = 3'd7; tick(acc); check("bp_acc2", 32'(acc), 32'd1);
    in_imm = 32'hFFFFFFFF; in_type = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      check("bp_in_ready_low", 32'(acc), 32'd0);
    end
    out_ready = 1'b1;
    tick(acc);
    check("bp_drain1", 32'(popped), 32'd1);
    check("bp_acc3", 32'(acc), 32'd1);
    in_valid = 1'b0;
    tick(acc);
    check("bp_drain2", 32'(popped), 32'd1);
    tick(acc);
    check("bp_drain3", 32'(popped), 32'd1);
    check("bp_queue_empty", 32'(q.size()), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_imm = 32'd1; in_type = 3'd0;
    tick(acc);
    tick(acc);
    in_valid = 1'b0;
    check("full_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      check("rst_no_emerge", 32'(out_valid), 32'd0);
    end

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_type = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: in_imm = $urandom;
        1: in_imm = 32'($signed(12'($urandom)));
        2: in_imm = edges[$urandom_range(0, 11)];
        default: in_imm = $urandom & 32'hFFFFF000;
      endcase
      tick(acc);
    end

    // Drain
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick(acc);
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
